// File: rtl/alu_exec_unit.sv
// Execute stage: single-cycle logic/arithmetic ops plus an iterative shift-add multiplier.
// Optional signed-overflow flag for ADD/SUB is built only when ALU_OVERFLOW_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_ctr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_NOR = 3'b011,
        OP_MUL = 3'b100,
        OP_XOR = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    // The counter value seen on the edge that performs the final iteration.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           state_nx;
    op_e              op;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mul_add;
    logic [CNT_W-1:0] cnt;

    logic             accept_single;
    logic             accept_mul;
    logic             mul_last;

    assign op      = op_e'(alu_ctr);
    assign sum     = a + b;
    assign diff    = a - b;
    assign mul_add = mplier[0] ? (acc + mcand) : acc;
    assign busy    = (state == MUL);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        alu_res = '0;
        case (op)
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_ADD:  alu_res = sum;
            OP_NOR:  alu_res = ~(a | b);
            OP_XOR:  alu_res = a ^ b;
            OP_SUB:  alu_res = diff;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        accept_single = 1'b0;
        accept_mul    = 1'b0;
        mul_last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (op == OP_MUL) begin
                        accept_mul = 1'b1;
                        state_nx   = MUL;
                    end else begin
                        accept_single = 1'b1;
                    end
                end
            end
            MUL: begin
                if (cnt == CNT_LAST) begin
                    mul_last = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: multiplier working registers are reset too, so an aborted MUL leaves no residue.
            result <= '0;
            zero   <= 1'b1;
            done   <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (accept_single) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
                done   <= 1'b1;
            end
            if (accept_mul) begin
                mcand  <= a;
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
            end
            if (state == MUL) begin
                acc    <= mul_add;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (mul_last) begin
                    result <= mul_add;
                    zero   <= (mul_add == '0);
                    done   <= 1'b1;
                end
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic alu_ovf;

    // Signed overflow: result sign differs from a's sign when the operation could not flip it.
    always_comb begin
        alu_ovf = 1'b0;
        case (op)
            OP_ADD:  alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
            OP_SUB:  alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            default: alu_ovf = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (accept_single) begin
            overflow <= alu_ovf;
        end else if (mul_last) begin
            overflow <= 1'b0;
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed test-plan cases plus randomized ops against
// an arithmetic reference model; a monitor pops expectations whenever done pulses.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;

`ifdef ALU_OVERFLOW_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             z;
        logic             ovf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       alu_ctr = '0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .alu_ctr  (alu_ctr),
        .a        (a),
        .b        (b),
        .result   (result),
        .zero     (zero),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] res, input logic ovf);
        exp_t e;
        e.res = res;
        e.z   = (res == '0);
        e.ovf = ovf & OVF_ON;
        return e;
    endfunction

    // Reference model: plain wide arithmetic, overflow judged by range of the exact result.
    function automatic exp_t model(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                   input logic [WIDTH-1:0] y);
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint s  = 0;
        longint unsigned p;
        logic [WIDTH-1:0] r = '0;
        logic ovf = 1'b0;
        case (op)
            3'd0: r = x & y;
            3'd1: r = x | y;
            3'd2: begin s = sx + sy; r = WIDTH'(s); end
            3'd3: r = ~(x | y);
            3'd4: begin p = 64'(x) * 64'(y); r = WIDTH'(p); end
            3'd5: r = x ^ y;
            3'd6: begin s = sx - sy; r = WIDTH'(s); end
            default: r = (sx < sy) ? 1 : 0;
        endcase
        if (op == 3'd2 || op == 3'd6)
            ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return mk(r, ovf);
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", result, mon_e.res);
                check("zero", zero, mon_e.z);
                check("overflow", overflow, mon_e.ovf);
            end
        end
    end

    // Leaves start high after a single-cycle op so consecutive calls issue back-to-back.
    task automatic issue(input logic [2:0] op, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input exp_t e);
        int n;
        @(negedge clk);
        start   = 1'b1;
        alu_ctr = op;
        a       = x;
        b       = y;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (op != 3'd4) begin
            check("done_latency", done, 1);
        end else begin
            start = 1'b0;
            check("busy_on_start", busy, 1);
            n = 0;
            for (int i = 0; i < WIDTH + 8; i++) begin
                @(negedge clk);
                if (done) break;
                if (busy) n++;
                start   = 1'($urandom_range(0, 1));
                alu_ctr = 3'($urandom);
                a       = $urandom;
                b       = $urandom;
            end
            start = 1'b0;
            check("mul_busy_cycles", n, WIDTH);
            check("mul_done_seen", done, 1);
        end
    endtask

    task automatic issue_rand(input logic [2:0] op, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y);
        issue(op, x, y, model(op, x, y));
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit saw_done;
        logic [2:0] op;

        #1 reset = 1'b1;
        #1;
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("idle_hold_result", result, 0);
        check("idle_done_low", done, 0);

        // Single-cycle ops from the test plan.
        issue(3'd2, 32'h0000_000F, 32'h0000_00F0, mk(32'h0000_00FF, 1'b0));
        idle();
        issue(3'd0, 32'h0000_000F, 32'h0000_00F0, mk(32'h0, 1'b0));
        idle();
        issue(3'd6, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1'b0));
        idle();
        issue(3'd7, 32'hFFFF_FFFF, 32'd1, mk(32'h1, 1'b0));
        idle();
        repeat (2) @(negedge clk);
        check("hold_after_idle", result, 32'h1);

        // Multiply.
        issue(3'd4, 32'd12345, 32'd678, mk(32'd8369910, 1'b0));
        issue(3'd4, 32'hFFFF_FFFF, 32'd2, mk(32'hFFFF_FFFE, 1'b0));

        // Back-to-back single-cycle ops.
        issue_rand(3'd2, $urandom, $urandom);
        issue_rand(3'd2, $urandom, $urandom);
        issue_rand(3'd5, $urandom, $urandom);
        idle();

        // Overflow cases.
        issue(3'd2, 32'h7FFF_FFFF, 32'd1, mk(32'h8000_0000, 1'b1));
        idle();
        issue(3'd6, 32'h8000_0000, 32'd1, mk(32'h7FFF_FFFF, 1'b1));
        idle();

        // Reset in the middle of a MUL aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; alu_ctr = 3'd4; a = 32'd1000; b = 32'd1000;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        saw_done = 1'b0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("no_done_after_abort", saw_done, 0);
        issue(3'd2, 32'd40, 32'd2, mk(32'd42, 1'b0));
        idle();

        // Randomized mix, with runs of back-to-back single-cycle ops.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            if (op == 3'd4 && $urandom_range(0, 2) != 0) op = 3'd2;
            case ($urandom_range(0, 3))
                0:       issue_rand(op, 32'h7FFF_FFFF - 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
                1:       issue_rand(op, 32'h8000_0000 + 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
                default: issue_rand(op, $urandom, $urandom);
            endcase
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
